valid_event_counter: RTL and testbench
======================================

# valid_event_counter

Registered event counter that produces the `count` stream consumed by the valid-increment checker stage. It adds one to `count` on every cycle where `valid` is sampled high with `en` asserted. It also exposes a one-cycle-delayed copy `count_prev`, wrap/saturation/threshold status, and a valid/ready snapshot port. It sits directly upstream of the checker, so `valid |=> count == count_prev + 1` (mod 2^WIDTH) holds except where `clr`, saturation or `en` intervene.

## Interface
- `WIDTH`, 8: counter width in bits.
- `SATURATE`, 0: 0 = wrap at max, 1 = hold at max.
- `THRESH`, 4: count value that fires `thr_hit`; must be nonzero and ≤ 2^WIDTH-1.

- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  count enable; when low, `valid` is ignored.
- `valid`  in  1  increment request, sampled each posedge.
- `clr`  in  1  synchronous clear of `count` and the threshold arm.
- `count`  out  WIDTH  current count, registered.
- `count_prev`  out  WIDTH  `count` delayed one cycle, registered.
- `incr`  out  1  registered pulse: `count` changed by +1 (including a wrap) at the last edge.
- `wrap`  out  1  registered pulse: `count` went max→0 at the last edge; always 0 when SATURATE=1.
- `sat`  out  1  level: SATURATE=1 and `count` == 2^WIDTH-1.
- `thr_hit`  out  1  registered pulse: `count` became THRESH while armed.
- `snap_req`  in  1  request a snapshot of `count`.
- `snap_valid`  out  1  snapshot held and valid.
- `snap_ready`  in  1  consumer accepts the snapshot.
- `snap_data`  out  WIDTH  captured count.

## Operation
- Priority at each edge: `rst` > `clr` > increment.
- Increment condition: `en && valid && !clr`. If SATURATE=1 and `count` is at max, no increment occurs and `incr` stays 0.
- Arithmetic is modulo 2^WIDTH. With SATURATE=0, max+1 yields 0 and sets `incr` and `wrap` for one cycle.
- `count_prev <= count` every non-reset cycle, including on `clr` and on idle cycles. It is a pure delay.
- `clr`: `count` becomes 0 and the threshold is re-armed. `incr`, `wrap` and `thr_hit` are 0 for that edge.
- Threshold arm flag:
  - Set on reset, `clr` and wrap.
  - Cleared when `count` transitions to THRESH.
  - `thr_hit` pulses only on that transition. It fires once per arm.
- Snapshot FSM, IDLE and HOLD:
  - IDLE: on `snap_req`, capture the current `count` (the pre-update value present that cycle) into `snap_data` and go to HOLD.
  - HOLD: `snap_valid`=1. `snap_data` stays stable and `snap_req` is ignored. On `snap_ready`, go to IDLE with `snap_valid`=0 from the next cycle.
  - The FSM is independent of `en` and `clr`.
- Reset values: `count`=0, `count_prev`=0, `incr`=0, `wrap`=0, `sat`=0, `thr_hit`=0, `snap_valid`=0, `snap_data`=0, FSM=IDLE, arm=1.
- `rst` mid-handshake drops `snap_valid` at the next edge; the snapshot is lost.

## Timing
- Latency from `valid` to `count` is 1 cycle: `valid` sampled at edge T gives the new `count` visible after T.
- `count_prev` lags `count` by exactly 1 cycle. At edge T+1, `count` == `count_prev`+1 for any increment at T.
- `incr`, `wrap` and `thr_hit` are asserted in the same cycle as the new `count` value.
- `sat` is combinational from `count`, with no extra delay.
- Snapshot handshake:
  - `snap_req` at edge T gives `snap_valid`=1 after T.
  - The transfer completes on the edge where `snap_valid && snap_ready`.
  - `snap_req` is not re-accepted until the cycle after completion, so the minimum snapshot period is 2 cycles.
- Back-to-back `valid` increments every cycle. There are no bubbles.

## Test plan
- Reset for 2 cycles, then `valid`=1 with `en`=1 for 3 cycles → `count` = 1, 2, 3 on successive cycles; `count_prev` = 0, 1, 2; `incr`=1 in each; `thr_hit` is not yet asserted.
- Continue to count 4 with THRESH=4 → `thr_hit` pulses exactly once. Further increments to 5 give no pulse. `clr` then a count back to 4 → pulses again.
- SATURATE=0, WIDTH=8: preload to 255 by counting, then `valid` → `count`=0, `wrap`=1, `incr`=1, `count_prev`=255.
- SATURATE=1: at 255 with `valid`=1 → `count` stays 255, `sat`=1, `incr`=0, `wrap`=0.
- Same-cycle `clr`=1 and `valid`=1 at `count`=7 → `count`=0, `incr`=0, `count_prev`=7. Also `en`=0 with `valid`=1 → `count` is unchanged.
- `snap_req` at `count`=10 while `valid` keeps incrementing; hold `snap_ready`=0 for 3 cycles, then 1 → `snap_data`=10 stays stable throughout and `snap_valid` drops the cycle after acceptance. A second `snap_req` during HOLD is ignored. Asserting `rst` during HOLD → `snap_valid`=0 and `count`=0 next cycle.

Source files
------------

// File: rtl/valid_event_counter.sv
// Registered valid-driven event counter with a one-cycle-delayed copy, wrap/saturate/threshold
// status pulses, and a single-entry valid/ready snapshot port.
module valid_event_counter #(
   parameter int unsigned WIDTH    = 8,
   parameter bit          SATURATE = 1'b0,
   parameter int unsigned THRESH   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             valid,
   input  logic             clr,
   output logic [WIDTH-1:0] count,
   output logic [WIDTH-1:0] count_prev,
   output logic             incr,
   output logic             wrap,
   output logic             sat,
   output logic             thr_hit,
   input  logic             snap_req,
   output logic             snap_valid,
   input  logic             snap_ready,
   output logic [WIDTH-1:0] snap_data
);

   localparam logic [WIDTH-1:0] MAX_V    = '1;
   localparam logic [WIDTH-1:0] THRESH_V = WIDTH'(THRESH);

   typedef enum logic {
      SNAP_IDLE = 1'b0,
      SNAP_HOLD = 1'b1
   } snap_state_e;

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] prev_q;
   logic             incr_q, incr_d;
   logic             wrap_q, wrap_d;
   logic             thr_q, thr_d;
   logic             arm_q, arm_d;
   logic [WIDTH-1:0] snap_data_q, snap_data_d;
   snap_state_e      state_q, state_d;

   logic at_max;
   logic inc_ok;

   // Counter, status pulses and threshold arm.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      count_d = count_q;
      incr_d  = 1'b0;
      wrap_d  = 1'b0;
      thr_d   = 1'b0;
      arm_d   = arm_q;
      at_max  = (count_q == MAX_V);
      inc_ok  = en && valid && !clr && !(SATURATE && at_max);

      if (clr) begin
         count_d = '0;
         arm_d   = 1'b1;
      end else if (inc_ok) begin
         count_d = count_q + WIDTH'(1);
         incr_d  = 1'b1;
         wrap_d  = at_max;
         thr_d   = arm_q && (count_d == THRESH_V);
         if (wrap_d) begin
            arm_d = 1'b1;
         end else if (count_d == THRESH_V) begin
            arm_d = 1'b0;
         end
      end
   end

   // Snapshot handshake: capture in IDLE, hold until the consumer accepts.
   always_comb begin
      state_d     = state_q;
      snap_data_d = snap_data_q;
      case (state_q)
         SNAP_IDLE: begin
            if (snap_req) begin
               snap_data_d = count_q;
               state_d     = SNAP_HOLD;
            end
         end
         SNAP_HOLD: begin
            if (snap_ready) begin
               state_d = SNAP_IDLE;
            end
         end
         default: state_d = SNAP_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all update together at the edge.
      if (rst) begin
         count_q     <= '0;
         prev_q      <= '0;
         incr_q      <= 1'b0;
         wrap_q      <= 1'b0;
         thr_q       <= 1'b0;
         arm_q       <= 1'b1;
         snap_data_q <= '0;
         state_q     <= SNAP_IDLE;
      end else begin
         count_q     <= count_d;
         prev_q      <= count_q;
         incr_q      <= incr_d;
         wrap_q      <= wrap_d;
         thr_q       <= thr_d;
         arm_q       <= arm_d;
         snap_data_q <= snap_data_d;
         state_q     <= state_d;
      end
   end

   assign count      = count_q;
   assign count_prev = prev_q;
   assign incr       = incr_q;
   assign wrap       = wrap_q;
   assign thr_hit    = thr_q;
   assign sat        = SATURATE && at_max;
   assign snap_valid = (state_q == SNAP_HOLD);
   assign snap_data  = snap_data_q;

endmodule

// File: tb/tb_valid_event_counter.sv
// Scoreboard bench for valid_event_counter: one wrapping and one saturating instance,
// directed vectors with hand-computed expectations, checked by an independent monitor.
module tb_valid_event_counter;

   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] cnt;
      logic [W-1:0] prv;
      logic         inc;
      logic         wr;
      logic         st;
      logic         th;
      logic         sv;
      logic [W-1:0] sd;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_a [2];
   logic         en_a  [2];
   logic         valid_a [2];
   logic         clr_a [2];
   logic         req_a [2];
   logic         rdy_a [2];
   logic [W-1:0] count_a [2];
   logic [W-1:0] prev_a [2];
   logic [W-1:0] sd_a [2];
   logic         incr_a [2];
   logic         wrap_a [2];
   logic         sat_a [2];
   logic         thr_a [2];
   logic         sv_a [2];

   valid_event_counter #(.WIDTH(W), .SATURATE(1'b0), .THRESH(4)) dut_wrap (
      .clk(clk), .rst(rst_a[0]), .en(en_a[0]), .valid(valid_a[0]), .clr(clr_a[0]),
      .count(count_a[0]), .count_prev(prev_a[0]), .incr(incr_a[0]), .wrap(wrap_a[0]),
      .sat(sat_a[0]), .thr_hit(thr_a[0]), .snap_req(req_a[0]), .snap_valid(sv_a[0]),
      .snap_ready(rdy_a[0]), .snap_data(sd_a[0])
   );

   valid_event_counter #(.WIDTH(W), .SATURATE(1'b1), .THRESH(4)) dut_sat (
      .clk(clk), .rst(rst_a[1]), .en(en_a[1]), .valid(valid_a[1]), .clr(clr_a[1]),
      .count(count_a[1]), .count_prev(prev_a[1]), .incr(incr_a[1]), .wrap(wrap_a[1]),
      .sat(sat_a[1]), .thr_hit(thr_a[1]), .snap_req(req_a[1]), .snap_valid(sv_a[1]),
      .snap_ready(rdy_a[1]), .snap_data(sd_a[1])
   );

   exp_t q0[$];
   exp_t q1[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic exp_t mk(input int cnt, input int prv, input bit inc, input bit wr,
                               input bit st, input bit th, input bit sv, input int sd);
      exp_t x;
      x.cnt = W'(cnt);
      x.prv = W'(prv);
      x.inc = inc;
      x.wr  = wr;
      x.st  = st;
      x.th  = th;
      x.sv  = sv;
      x.sd  = W'(sd);
      return x;
   endfunction

   task automatic check(input string name, input int d, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d @%0t: got %0h, expected %0h", name, d, $time, act, exp);
      end
   endtask

   task automatic compare(input int d, input exp_t x);
      check("count",      d, 32'(count_a[d]), 32'(x.cnt));
      check("count_prev", d, 32'(prev_a[d]),  32'(x.prv));
      check("incr",       d, 32'(incr_a[d]),  32'(x.inc));
      check("wrap",       d, 32'(wrap_a[d]),  32'(x.wr));
      check("sat",        d, 32'(sat_a[d]),   32'(x.st));
      check("thr_hit",    d, 32'(thr_a[d]),   32'(x.th));
      check("snap_valid", d, 32'(sv_a[d]),    32'(x.sv));
      check("snap_data",  d, 32'(sd_a[d]),    32'(x.sd));
   endtask

   // Drive one cycle of inputs at the falling edge; expectation is for after the next rising edge.
   task automatic step(input int d, input logic r, input logic e, input logic v, input logic c,
                       input logic rq, input logic rd, input exp_t x);
      @(negedge clk);
      rst_a[d]   = r;
      en_a[d]    = e;
      valid_a[d] = v;
      clr_a[d]   = c;
      req_a[d]   = rq;
      rdy_a[d]   = rd;
      if (d == 0) q0.push_back(x);
      else        q1.push_back(x);
   endtask

   initial begin : monitor
      exp_t x;
      forever begin
         @(posedge clk);
         #2;
         if (q0.size() > 0) begin
            x = q0.pop_front();
            compare(0, x);
         end
         if (q1.size() > 0) begin
            x = q1.pop_front();
            compare(1, x);
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      for (int d = 0; d < 2; d++) begin
         rst_a[d] = 1'b1; en_a[d] = 1'b0; valid_a[d] = 1'b0;
         clr_a[d] = 1'b0; req_a[d] = 1'b0; rdy_a[d] = 1'b0;
      end

      // Wrapping instance: reset, first counts, threshold pulse.
      step(0, 1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
      step(0, 1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 1; i <= 3; i++) step(0, 0, 1, 1, 0, 0, 0, mk(i, i - 1, 1, 0, 0, 0, 0, 0));
      step(0, 0, 1, 1, 0, 0, 0, mk(4, 3, 1, 0, 0, 1, 0, 0));
      step(0, 0, 1, 1, 0, 0, 0, mk(5, 4, 1, 0, 0, 0, 0, 0));
      step(0, 0, 1, 0, 1, 0, 0, mk(0, 5, 0, 0, 0, 0, 0, 0));
      for (int i = 1; i <= 7; i++)
         step(0, 0, 1, 1, 0, 0, 0, mk(i, i - 1, 1, 0, 0, (i == 4), 0, 0));
      // clr beats a same-cycle increment; en low masks valid.
      step(0, 0, 1, 1, 1, 0, 0, mk(0, 7, 0, 0, 0, 0, 0, 0));
      step(0, 0, 0, 1, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
      // Count to max, wrap, and confirm the wrap re-arms the threshold.
      for (int i = 1; i <= 255; i++)
         step(0, 0, 1, 1, 0, 0, 0, mk(i, i - 1, 1, 0, 0, (i == 4), 0, 0));
      step(0, 0, 1, 1, 0, 0, 0, mk(0, 255, 1, 1, 0, 0, 0, 0));
      for (int i = 1; i <= 4; i++)
         step(0, 0, 1, 1, 0, 0, 0, mk(i, i - 1, 1, 0, 0, (i == 4), 0, 0));
      step(0, 0, 1, 0, 1, 0, 0, mk(0, 4, 0, 0, 0, 0, 0, 0));
      for (int i = 1; i <= 10; i++)
         step(0, 0, 1, 1, 0, 0, 0, mk(i, i - 1, 1, 0, 0, (i == 4), 0, 0));
      // Snapshot at count 10 while counting; stall, ignored re-request, accept, re-request.
      step(0, 0, 1, 1, 0, 1, 0, mk(11, 10, 1, 0, 0, 0, 1, 10));
      for (int k = 0; k < 3; k++)
         step(0, 0, 1, 1, 0, (k == 1), 0, mk(12 + k, 11 + k, 1, 0, 0, 0, 1, 10));
      step(0, 0, 1, 1, 0, 1, 1, mk(15, 14, 1, 0, 0, 0, 0, 10));
      step(0, 0, 1, 1, 0, 1, 0, mk(16, 15, 1, 0, 0, 0, 1, 15));
      step(0, 1, 1, 1, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
      step(0, 0, 1, 1, 0, 0, 0, mk(1, 0, 1, 0, 0, 0, 0, 0));

      // Saturating instance: climb to max, hold there, clear.
      step(1, 1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
      step(1, 1, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 1; i <= 255; i++)
         step(1, 0, 1, 1, 0, 0, 0, mk(i, i - 1, 1, 0, (i == 255), (i == 4), 0, 0));
      step(1, 0, 1, 1, 0, 0, 0, mk(255, 255, 0, 0, 1, 0, 0, 0));
      step(1, 0, 1, 1, 0, 0, 0, mk(255, 255, 0, 0, 1, 0, 0, 0));
      step(1, 0, 1, 0, 1, 0, 0, mk(0, 255, 0, 0, 0, 0, 0, 0));
      step(1, 0, 1, 1, 0, 0, 0, mk(1, 0, 1, 0, 0, 0, 0, 0));

      for (int k = 0; k < 10 && (q0.size() > 0 || q1.size() > 0); k++) @(negedge clk);
      if (q0.size() > 0 || q1.size() > 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", q0.size() + q1.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
